// File: rtl/ps2_rx_port.sv
// PS/2 keyboard receiver feeding VIA port A through a small scancode FIFO.
// Define PS2_RX_PARITY_EN to reject frames that fail odd parity.
module ps2_rx_port #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FILT           = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ack,
  input  logic       err_clr,
  output logic [7:0] port_out,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]    cs;
  logic [1:0]    ds;
  logic          flt;
  logic          flt_d;
  logic [FW-1:0] fcnt;
  logic          fall;
  logic          d_s;

  state_t        state;
  state_t        state_n;
  logic [7:0]    shreg;
  logic [2:0]    bcnt;
  logic          par;
  logic [15:0]   tcnt;
  logic          timeout;
  logic          par_ok;
  logic          push_req;
  logic          ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW-1:0] rd_n;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_n;
  logic          ack_d;
  logic          pop_do;
  logic          push_do;
  logic          ovf_set;
  logic [7:0]    head_n;

  assign d_s  = ds[1];
  assign fall = ~flt & flt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs    <= 2'b11;
      ds    <= 2'b11;
      flt   <= 1'b1;
      flt_d <= 1'b1;
      fcnt  <= '0;
    end else begin
      cs    <= {cs[0], ps2_clk};
      ds    <= {ds[0], ps2_data};
      flt_d <= flt;
      if (cs[1] != flt) begin
        if (fcnt == FW'(FILT - 1)) begin
          flt  <= cs[1];
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign timeout = (state != IDLE) &&
                   (tcnt == 16'(TIMEOUT_CYCLES));

`ifdef PS2_RX_PARITY_EN
  assign par_ok = ^{shreg, par};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (timeout) begin
      state_n = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE:   if (!d_s) state_n = DATA;
        DATA:   if (bcnt == 3'd7) state_n = PARITY;
        PARITY: state_n = STOP;
        STOP:   state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    push_req = 1'b0;
    ferr_set = timeout;
    if (fall && !timeout && state == STOP) begin
      push_req = d_s & par_ok;
      ferr_set = ~(d_s & par_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      bcnt  <= '0;
      par   <= 1'b0;
      tcnt  <= '0;
    end else begin
      tcnt <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
      if (fall) begin
        unique case (state)
          IDLE: bcnt <= '0;
          DATA: begin
            shreg <= {d_s, shreg[7:1]};
            bcnt  <= bcnt + 1'b1;
          end
          PARITY: par <= d_s;
          STOP: ;
        endcase
      end
    end
  end

  // Pop only on an ack rising edge; a pop frees room for a same-cycle push.
  assign pop_do  = ack & ~ack_d & (cnt != '0);
  assign push_do = push_req &
                   ((cnt != (AW+1)'(FIFO_DEPTH)) | pop_do);
  assign ovf_set = push_req & ~push_do;
  assign cnt_n   = cnt + (AW+1)'(push_do) - (AW+1)'(pop_do);
  assign rd_n    = rd + AW'(pop_do);

  always_comb begin
    head_n = mem[rd_n];
    if (cnt_n == '0)
      head_n = 8'h00;
    else if (push_do && cnt_n == (AW+1)'(1))
      head_n = shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd         <= '0;
      wr         <= '0;
      cnt        <= '0;
      ack_d      <= 1'b0;
      port_out   <= 8'h00;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ack_d <= ack;
      if (push_do) begin
        mem[wr] <= shreg;
        wr      <= wr + 1'b1;
      end
      rd         <= rd_n;
      cnt        <= cnt_n;
      port_out   <= head_n;
      data_ready <= (cnt_n != '0);
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovf_set)      overflow  <= 1'b1;
      else if (err_clr) overflow  <= 1'b0;
    end
  end

endmodule
